// File: rtl/bias_arb_pkg.sv
// Shared constants and types for the bias SRAM arbiter.
// Optional feature macro: BIAS_ARB_RR_EN (see bias_arb_pick).
package bias_arb_pkg;

  localparam int BIAS_ADDR_BITS = 9;
  localparam int BIAS_DATA_W    = 32;

  // SRAM pin levels when no access (CEN) or when reading (WEN); both active-low pins.
  localparam logic CEN_OFF  = 1'b1;
  localparam logic WEN_READ = 1'b1;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } gnt_src_e;

endpackage

// File: rtl/bias_arb_pick.sv
// Grant decision for the bias SRAM: write priority with a read starvation bound,
// or (BIAS_ARB_RR_EN defined) round-robin alternation on simultaneous requests.
module bias_arb_pick
  import bias_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     wr_req,
  input  logic     rd_req,
  output gnt_src_e gnt_src,
  output logic     starve_hit
);

`ifdef BIAS_ARB_RR_EN

  logic last_rd_d;
  logic last_rd_q;

  // Alternate on contention; the pointer remembers which side won last.
  always_comb begin
    gnt_src   = NONE;
    last_rd_d = last_rd_q;
    if (reset) begin
      gnt_src = NONE;
    end else if (wr_req && rd_req) begin
      if (last_rd_q) begin
        gnt_src   = WR;
        last_rd_d = 1'b0;
      end else begin
        gnt_src   = RD;
        last_rd_d = 1'b1;
      end
    end else if (wr_req) begin
      gnt_src   = WR;
      last_rd_d = 1'b0;
    end else if (rd_req) begin
      gnt_src   = RD;
      last_rd_d = 1'b1;
    end else begin
      gnt_src = NONE;
    end
  end

  // Reset to "read went last" so the writer wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_rd_q <= 1'b1;
    end else begin
      last_rd_q <= last_rd_d;
    end
  end

  assign starve_hit = 1'b0;

`else

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_d;
  logic [3:0] starve_cnt_q;

  // Writer wins contention until the waiting read has lost STARVE_MAX times in a row.
  always_comb begin
    gnt_src      = NONE;
    starve_hit   = 1'b0;
    starve_cnt_d = 4'd0;
    if (reset) begin
      gnt_src = NONE;
    end else if (wr_req && rd_req) begin
      if (starve_cnt_q >= STARVE_LIM) begin
        gnt_src    = RD;
        starve_hit = 1'b1;
      end else begin
        gnt_src      = WR;
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end else if (wr_req) begin
      gnt_src = WR;
    end else if (rd_req) begin
      gnt_src = RD;
    end else begin
      gnt_src = NONE;
    end
  end

  // Starvation count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

`endif

endmodule

// File: rtl/bias_sram_arb.sv
// Bias SRAM arbiter top: registered SRAM pins and a 2-stage read-tag pipeline.
// Build option: define BIAS_ARB_RR_EN for round-robin arbitration.
module bias_sram_arb
  import bias_arb_pkg::*;
#(
  parameter int ADDR_BITS  = BIAS_ADDR_BITS,
  parameter int DATA_W     = BIAS_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_din,
  output logic                 wr_gnt,
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_gnt,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_dout,
  output logic                 cen_bias,
  output logic                 wen_bias,
  output logic [ADDR_BITS-1:0] addr_bias,
  output logic [DATA_W-1:0]    din_bias,
  input  logic [DATA_W-1:0]    q_bias,
  output logic                 starve_hit
);

  gnt_src_e gnt_src;

  logic                 cen_d,  cen_q;
  logic                 wen_d,  wen_q;
  logic [ADDR_BITS-1:0] addr_d, addr_q;
  logic [DATA_W-1:0]    din_d,  din_q;
  logic [1:0]           tag_d,  tag_q;

  bias_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk        (clk),
    .reset      (reset),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .gnt_src    (gnt_src),
    .starve_hit (starve_hit)
  );

  assign wr_gnt = (gnt_src == WR);
  assign rd_gnt = (gnt_src == RD);

  // Next SRAM pin values from this cycle's grant; address/data hold when idle.
  always_comb begin
    cen_d  = CEN_OFF;
    wen_d  = WEN_READ;
    addr_d = addr_q;
    din_d  = din_q;
    case (gnt_src)
      WR: begin
        cen_d  = 1'b0;
        wen_d  = 1'b0;
        addr_d = wr_addr;
        din_d  = wr_din;
      end
      RD: begin
        cen_d  = 1'b0;
        wen_d  = WEN_READ;
        addr_d = rd_addr;
      end
      NONE: begin
        cen_d = CEN_OFF;
        wen_d = WEN_READ;
      end
      default: begin
        cen_d = CEN_OFF;
        wen_d = WEN_READ;
      end
    endcase
    tag_d = {tag_q[0], rd_gnt};
  end

  // SRAM pin and read-tag registers; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cen_q  <= CEN_OFF;
      wen_q  <= WEN_READ;
      addr_q <= '0;
      din_q  <= '0;
      tag_q  <= 2'b00;
    end else begin
      cen_q  <= cen_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      tag_q  <= tag_d;
    end
  end

  assign cen_bias  = cen_q;
  assign wen_bias  = wen_q;
  assign addr_bias = addr_q;
  assign din_bias  = din_q;
  assign rd_valid  = tag_q[1];
  // SRAM output is already registered inside the macro; pass it straight through.
  assign rd_dout   = q_bias;

endmodule

// File: tb/tb_bias_sram_arb.sv
// Randomized self-checking bench for bias_sram_arb with an SRAM model and a
// transaction-level reference (shadow memory + expected read-return queue).
module tb_bias_sram_arb;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_din;
  logic          wr_gnt, rd_gnt, rd_valid, starve_hit;
  logic [DW-1:0] rd_dout, q_bias, din_bias;
  logic          cen_bias, wen_bias;
  logic [AW-1:0] addr_bias;

  always #5 clk = ~clk;

  bias_sram_arb #(.ADDR_BITS(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_din(wr_din), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_dout(rd_dout),
    .cen_bias(cen_bias), .wen_bias(wen_bias), .addr_bias(addr_bias), .din_bias(din_bias),
    .q_bias(q_bias), .starve_hit(starve_hit)
  );

  // Single-port SRAM model: access when cen low, read data appears the following cycle.
  logic [DW-1:0] sram [0:511];
  always @(posedge clk) begin
    if (!cen_bias) begin
      if (!wen_bias) sram[addr_bias] <= din_bias;
      else           q_bias <= sram[addr_bias];
    end
  end

  typedef struct { int due; logic [DW-1:0] d; } rd_exp_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            loses = 0;
  bit            last_rd = 1'b1;
  bit            exp_cen = 1'b1, exp_wen = 1'b1;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_din = '0;
  logic [DW-1:0] shadow [0:63];
  rd_exp_t       rq [$];
  bit            last_ew, last_er;
  bit            wr_pend = 1'b0, rd_pend = 1'b0;
  int            obs_rg, obs_hit;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: check DUT against the model at negedge, then advance the model.
  task automatic step();
    bit ew, er, eh, ev;
    @(negedge clk);
    ew = 1'b0; er = 1'b0; eh = 1'b0;
    if (!reset) begin
      if (wr_req && rd_req) begin
`ifdef BIAS_ARB_RR_EN
        if (last_rd) ew = 1'b1; else er = 1'b1;
`else
        if (loses == SM) begin er = 1'b1; eh = 1'b1; end
        else ew = 1'b1;
`endif
      end else begin
        ew = wr_req;
        er = rd_req;
      end
    end
    ev = (rq.size() > 0) && (rq[0].due == cyc);
    check_val("wr_gnt",     64'(wr_gnt),     64'(ew));
    check_val("rd_gnt",     64'(rd_gnt),     64'(er));
    check_val("starve_hit", 64'(starve_hit), 64'(eh));
    check_val("cen_bias",   64'(cen_bias),   64'(exp_cen));
    check_val("wen_bias",   64'(wen_bias),   64'(exp_wen));
    check_val("addr_bias",  64'(addr_bias),  64'(exp_addr));
    check_val("din_bias",   64'(din_bias),   64'(exp_din));
    check_val("rd_valid",   64'(rd_valid),   64'(ev));
    if (ev) begin
      check_val("rd_dout", 64'(rd_dout), 64'(rq[0].d));
      void'(rq.pop_front());
    end
    obs_rg  += int'(rd_gnt);
    obs_hit += int'(starve_hit);
    if (reset) begin
      loses = 0; last_rd = 1'b1;
      exp_cen = 1'b1; exp_wen = 1'b1; exp_addr = '0; exp_din = '0;
      rq.delete();
    end else begin
      if (wr_req && rd_req && ew) loses++; else loses = 0;
      if (ew) last_rd = 1'b0;
      if (er) last_rd = 1'b1;
      exp_cen = !(ew || er);
      exp_wen = !ew;
      if (ew) begin
        exp_addr = wr_addr; exp_din = wr_din;
        shadow[wr_addr[5:0]] = wr_din;
      end
      if (er) begin
        exp_addr = rd_addr;
        rq.push_back('{due: cyc + 2, d: shadow[rd_addr[5:0]]});
      end
    end
    last_ew = ew; last_er = er;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic drive_rand(input int wr_pct, input int rd_pct);
    if (!wr_pend) begin
      if (int'($urandom_range(0, 99)) < wr_pct) begin
        wr_pend = 1'b1; wr_addr = 9'($urandom_range(0, 63)); wr_din = $urandom;
      end
    end else if ($urandom_range(0, 15) == 0) begin
      wr_pend = 1'b0;
    end
    if (!rd_pend) begin
      if (int'($urandom_range(0, 99)) < rd_pct) begin
        rd_pend = 1'b1; rd_addr = 9'($urandom_range(0, 63));
      end
    end else if ($urandom_range(0, 15) == 0) begin
      rd_pend = 1'b0;
    end
    wr_req = wr_pend; rd_req = rd_pend;
  endtask

  initial begin
    reset = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 9'd3; rd_addr = 9'd4; wr_din = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with both requests high to show grants are suppressed.
    step(); step();
    reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    step();

    // Write stream: 64 back-to-back writes, data 0x100+addr.
    for (int i = 0; i < 64; i++) begin
      wr_req = 1'b1; wr_addr = 9'(i); wr_din = 32'h100 + 32'(i);
      step();
    end
    wr_req = 1'b0;

    // Single read of address 5.
    rd_req = 1'b1; rd_addr = 9'd5;
    step();
    rd_req = 1'b0;
    step(); step();

    // Continuous dual requests for 20 cycles.
    obs_rg = 0; obs_hit = 0;
    wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 9'd10; wr_din = $urandom; rd_addr = 9'd20;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_ew) begin wr_addr = 9'($urandom_range(0, 63)); wr_din = $urandom; end
      if (last_er) rd_addr = 9'($urandom_range(0, 63));
    end
`ifdef BIAS_ARB_RR_EN
    check_val("dual_rd_grants", 64'(obs_rg), 64'd10);
    check_val("dual_hits",      64'(obs_hit), 64'd0);
`else
    check_val("dual_rd_grants", 64'(obs_rg), 64'd4);
    check_val("dual_hits",      64'(obs_hit), 64'd4);
`endif
    wr_req = 1'b0; rd_req = 1'b0;
    step(); step();

    // Same-address hazard: write 7 then read 7 the next cycle.
    wr_req = 1'b1; wr_addr = 9'd7; wr_din = 32'hDEAD;
    step();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 9'd7;
    step();
    rd_req = 1'b0;
    step(); step();

    // Reset one cycle after a read grant: the read must never return.
    rd_req = 1'b1; rd_addr = 9'd3;
    step();
    rd_req = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();

    // Randomized traffic with held requests and occasional drops.
    for (int i = 0; i < 400; i++) begin
      drive_rand((i < 200) ? 70 : 95, (i < 200) ? 50 : 95);
      step();
      if (last_ew) wr_pend = 1'b0;
      if (last_er) rd_pend = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (4) step();
    check_val("drain_empty", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bias_sram_arb.md
# bias_sram_arb

Arbiter and access sequencer for the single-port bias SRAM (32-bit words, 9-bit address). It shares the SRAM between the bias write path and the bias read path. The write path streams FIFO words into the SRAM. The read path fetches per-output-channel bias for the PE array. The arbiter grants at most one access per cycle, registers the SRAM control pins and returns read data with a fixed latency. A starvation counter bounds read wait time while the writer streams continuously.

## Interface
Parameters:
- ADDR_BITS, 9, SRAM address width
- DATA_W, 32, SRAM word width
- STARVE_MAX, 4, consecutive lost read arbitrations before the read is forced to win; range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_req  in  1  write request; wr_addr and wr_din are held stable until wr_gnt
- wr_addr  in  ADDR_BITS  write address
- wr_din  in  DATA_W  write data
- wr_gnt  out  1  combinational; write accepted this cycle
- rd_req  in  1  read request; rd_addr is held stable until rd_gnt
- rd_addr  in  ADDR_BITS  read address
- rd_gnt  out  1  combinational; read accepted this cycle
- rd_valid  out  1  read data valid
- rd_dout  out  DATA_W  read data; valid only while rd_valid
- cen_bias  out  1  SRAM chip enable, active-low, registered
- wen_bias  out  1  SRAM write enable, active-low, registered
- addr_bias  out  ADDR_BITS  SRAM address, registered
- din_bias  out  DATA_W  SRAM write data, registered
- q_bias  in  DATA_W  SRAM read data, valid the cycle after the SRAM access cycle
- starve_hit  out  1  one-cycle pulse when a read is forced to win

## Operation
- Arbitration runs every cycle and is combinational from wr_req, rd_req and the starvation count (starve_cnt, 4 bits).
  - Only one request present: that request is granted.
  - Both present and starve_cnt < STARVE_MAX: the write is granted, and starve_cnt increments.
  - Both present and starve_cnt == STARVE_MAX: the read is granted, starve_cnt clears, and starve_hit pulses.
  - Any cycle with a read grant, or with rd_req low: starve_cnt clears.
- Each request/grant pair is one beat. A requester holding req high receives back-to-back grants with no idle cycle. A request dropped before its grant is discarded with no side effect.
- At the edge ending a grant cycle:
  - Write grant: cen_bias=0, wen_bias=0, addr_bias=wr_addr, din_bias=wr_din.
  - Read grant: cen_bias=0, wen_bias=1, addr_bias=rd_addr. din_bias keeps its previous value.
  - No grant: cen_bias=1, wen_bias=1. addr_bias and din_bias hold.
- A one-bit read-tag pipeline (2 stages) follows each read grant. rd_valid is stage 2. rd_dout passes q_bias through unregistered.
- Same-address write then read in consecutive grants returns the new data, because the SRAM performs the accesses in order. No bypass logic exists.

## Timing
- Reset values: cen_bias=1, wen_bias=1, addr_bias=0, din_bias=0, rd_valid=0, starve_hit=0, starve_cnt=0, tag pipeline=0. wr_gnt and rd_gnt are 0 while reset is high.
- Read latency: grant in cycle t, SRAM access in cycle t+1, rd_valid=1 with rd_dout=q_bias in cycle t+2.
- Write latency: grant in cycle t, SRAM write in cycle t+1.
- Throughput: 1 access/cycle. With continuous dual requests and STARVE_MAX=4, the grant pattern repeats W W W W R.
- Reset asserted mid-operation: in-flight reads are dropped, so no rd_valid appears after reset. The SRAM is idle from the first cycle after the reset edge.

## Configuration
- BIAS_ARB_RR_EN defined: when both requests are present, grants alternate using a last-grant pointer (reset value: last=read, so the write wins first). The starvation counter is removed and starve_hit is tied to 0.
- BIAS_ARB_RR_EN undefined: write-priority arbitration with the starvation counter, as described above.

## Structure
- Shared package bias_arb_pkg holds:
  - BIAS_ADDR_BITS and BIAS_DATA_W constants.
  - SRAM inactive levels CEN_OFF=1 and WEN_READ=1.
  - An enum for the grant source: NONE, WR, RD.
- One sub-module, bias_arb_pick: combinational grant decision plus the starvation counter / last-grant pointer register. It contains the only code under the BIAS_ARB_RR_EN macro.
- The top level holds the SRAM pin registers and the read-tag pipeline.

## Test plan
- Write-only stream: wr_req held high for 64 cycles, addresses 0..63, data 0x100+addr. Required: 64 consecutive wr_gnt, and cen_bias/wen_bias low for 64 cycles starting 1 cycle later.
- Read-only request: rd_req held high at addr 5 after address 5 was written with 0x105. Required: rd_gnt at t, rd_valid at t+2 with rd_dout=0x105.
- Continuous dual requests, STARVE_MAX=4, macro off. Required: grant pattern W W W W R repeating, and starve_hit on each R.
- Same-address hazard: write addr 7 = 0xDEAD, then read addr 7 granted the next cycle. Required: rd_dout=0xDEAD.
- Reset asserted one cycle after a read grant. Required: no rd_valid, cen_bias=1 after reset, and starve_cnt=0.
- Macro BIAS_ARB_RR_EN on, continuous dual requests. Required: grants alternate W R W R, and starve_hit stays 0.
